pipeline_fetch: RTL and testbench

RV32 instruction fetch stage. It owns the fetch PC and issues in-order word requests to instruction memory over a req/gnt/rvalid interface. It buffers returned words in a small FIFO and presents instruction plus PC and PC+4 to the decode stage, with stall backpressure from decode and redirect/flush from branch or jump resolution. It is the producer side of the decode stage's instruction and PC inputs.

---
 rtl/pipeline_fetch.sv | 128 ++++++++++++
 tb/tb_pipeline_fetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_fetch.sv
// RV32 instruction fetch stage: owns the fetch PC, issues in-order word requests to
// instruction memory and buffers returned words for decode, honouring stall and redirect.
module pipeline_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        instr_valid_o,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic [31:0] pcsrc_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [SW-1:0] DEPTH_C = SW'(FIFO_DEPTH);
  localparam logic [31:0]   NOP_C   = 32'h0000_0013;

  logic [31:0]           fetch_pc_r;
  logic [31:0]           pc_mem_r   [FIFO_DEPTH];
  logic [31:0]           data_mem_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] filled_r;
  // Pointers carry one wrap bit so that a full buffer and an empty one differ.
  logic [CW-1:0]         head_r;
  logic [CW-1:0]         fill_r;
  logic [CW-1:0]         tail_r;
  logic [CW-1:0]         drop_cnt_r;

  logic [CW-1:0] alloc_cnt_s;
  logic [CW-1:0] unfilled_s;
  logic [CW-1:0] flush_drop_s;
  logic [SW-1:0] credit_s;
  logic [PW-1:0] head_idx_s;
  logic [PW-1:0] fill_idx_s;
  logic [PW-1:0] tail_idx_s;
  logic          outstanding_s;
  logic          grant_s;
  logic          fill_s;
  logic          pop_s;
  logic          head_valid_s;
  logic          unused_pc_bits_s;

  assign unused_pc_bits_s = ^redirect_pc_i[1:0];

  always_comb begin
    alloc_cnt_s   = tail_r - head_r;
    unfilled_s    = tail_r - fill_r;
    head_idx_s    = head_r[PW-1:0];
    fill_idx_s    = fill_r[PW-1:0];
    tail_idx_s    = tail_r[PW-1:0];
    credit_s      = SW'(alloc_cnt_s) + SW'(drop_cnt_r);
    outstanding_s = (drop_cnt_r != CW'(0)) || (unfilled_s != CW'(0));
    imem_req_o    = ~rst_i & ~redirect_i & (credit_s < DEPTH_C);
    imem_addr_o   = fetch_pc_r;
    grant_s       = imem_req_o & imem_gnt_i;
    // A response retires an orphaned request first; only then does it fill the oldest slot.
    fill_s        = ~rst_i & ~redirect_i & imem_rvalid_i &
                    (drop_cnt_r == CW'(0)) & (unfilled_s != CW'(0));
    head_valid_s  = ~rst_i & (alloc_cnt_s != CW'(0)) & filled_r[head_idx_s];
    pop_s         = head_valid_s & ~stall_i & ~redirect_i;
    flush_drop_s  = drop_cnt_r + unfilled_s - CW'(imem_rvalid_i & outstanding_s);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_r <= RESET_PC;
      head_r     <= CW'(0);
      fill_r     <= CW'(0);
      tail_r     <= CW'(0);
      drop_cnt_r <= CW'(0);
      filled_r   <= {FIFO_DEPTH{1'b0}};
    end else if (redirect_i) begin
      fetch_pc_r <= {redirect_pc_i[31:2], 2'b00};
      head_r     <= tail_r;
      fill_r     <= tail_r;
      drop_cnt_r <= flush_drop_s;
    end else begin
      if (grant_s) begin
        fetch_pc_r           <= fetch_pc_r + 32'd4;
        tail_r               <= tail_r + CW'(1);
        filled_r[tail_idx_s] <= 1'b0;
      end
      if (pop_s) begin
        head_r <= head_r + CW'(1);
      end
      if (fill_s) begin
        fill_r               <= fill_r + CW'(1);
        filled_r[fill_idx_s] <= 1'b1;
      end
      if (imem_rvalid_i && (drop_cnt_r != CW'(0))) begin
        drop_cnt_r <= drop_cnt_r - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant_s) begin
      pc_mem_r[tail_idx_s] <= fetch_pc_r;
    end
    if (fill_s) begin
      data_mem_r[fill_idx_s] <= imem_rdata_i;
    end
  end

  always_comb begin
    instr_valid_o = head_valid_s;
    if (head_valid_s) begin
      instruction_o = data_mem_r[head_idx_s];
      pc_o          = pc_mem_r[head_idx_s];
      pcsrc_o       = pc_mem_r[head_idx_s] + 32'd4;
    end else begin
      instruction_o = NOP_C;
      pc_o          = 32'h0000_0000;
      pcsrc_o       = 32'h0000_0004;
    end
  end

endmodule

// File: tb/tb_pipeline_fetch.sv
// Directed bench for pipeline_fetch: a small in-order memory responder with
// programmable latency, and hand-computed expectations checked each cycle.
module tb_pipeline_fetch;

  logic        clk;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        instr_valid_o;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic [31:0] pcsrc_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          mem_lat  = 1;
  int          cyc_cnt  = 0;
  logic [31:0] addr_q [$];
  int          due_q  [$];

  pipeline_fetch dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .instr_valid_o (instr_valid_o),
    .instruction_o (instruction_o),
    .pc_o          (pc_o),
    .pcsrc_o       (pcsrc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word 0 holds addi x1,x0,5; every other word is tagged with its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    mem_word = (a == 32'h0000_0000) ? 32'h0050_0093 : (32'h1000_0000 | a);
  endfunction

  // In-order responder: a grant seen at an edge answers mem_lat cycles later.
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (rst_i) begin
      addr_q.delete();
      due_q.delete();
      imem_rvalid_i <= 1'b0;
      imem_rdata_i  <= 32'h0000_0000;
    end else begin
      if (imem_req_o && imem_gnt_i) begin
        addr_q.push_back(imem_addr_o);
        due_q.push_back(cyc_cnt + mem_lat - 1);
      end
      if ((addr_q.size() > 0) && (due_q[0] <= cyc_cnt)) begin
        imem_rvalid_i <= 1'b1;
        imem_rdata_i  <= mem_word(addr_q[0]);
        void'(addr_q.pop_front());
        void'(due_q.pop_front());
      end else begin
        imem_rvalid_i <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i         = 1'b1;
    imem_gnt_i    = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0000_0000;
    stall_i       = 1'b0;
    mem_lat       = 1;
    nxt(); nxt(); #2;
    chk1("rst_req", imem_req_o, 1'b0);
    chk1("rst_valid", instr_valid_o, 1'b0);
    chk("rst_instr", instruction_o, 32'h0000_0013);
    chk("rst_pc", pc_o, 32'h0000_0000);
    chk("rst_pcsrc", pcsrc_o, 32'h0000_0004);

    // Streaming fetch from reset, latency 1
    nxt(); rst_i = 1'b0; #2;
    chk1("s1_c0_req", imem_req_o, 1'b1);
    chk("s1_c0_addr", imem_addr_o, 32'h0000_0000);
    nxt(); #2;
    chk1("s1_c1_valid", instr_valid_o, 1'b0);
    chk("s1_c1_addr", imem_addr_o, 32'h0000_0004);
    nxt(); #2;
    chk1("s1_c2_valid", instr_valid_o, 1'b1);
    chk("s1_c2_instr", instruction_o, 32'h0050_0093);
    chk("s1_c2_pc", pc_o, 32'h0000_0000);
    chk("s1_c2_pcsrc", pcsrc_o, 32'h0000_0004);
    nxt(); #2;
    chk("s1_c3_pc", pc_o, 32'h0000_0004);
    chk("s1_c3_instr", instruction_o, 32'h1000_0004);
    nxt(); #2;
    chk("s1_c4_pc", pc_o, 32'h0000_0008);
    nxt(); #2;
    chk("s1_c5_pc", pc_o, 32'h0000_000C);
    chk("s1_c5_pcsrc", pcsrc_o, 32'h0000_0010);

    // Grant withheld for three cycles: request must stay parked on 0x0
    nxt(); rst_i = 1'b1; imem_gnt_i = 1'b0; #2;
    nxt(); rst_i = 1'b0; #2;
    chk("s2_c0_addr", imem_addr_o, 32'h0000_0000);
    nxt(); #2;
    chk1("s2_c1_req", imem_req_o, 1'b1);
    chk("s2_c1_addr", imem_addr_o, 32'h0000_0000);
    nxt(); #2;
    chk("s2_c2_addr", imem_addr_o, 32'h0000_0000);
    nxt(); imem_gnt_i = 1'b1; #2;
    chk1("s2_c3_req", imem_req_o, 1'b1);
    chk("s2_c3_addr", imem_addr_o, 32'h0000_0000);
    nxt(); #2;
    chk("s2_c4_addr", imem_addr_o, 32'h0000_0004);
    nxt(); #2;
    chk1("s2_c5_valid", instr_valid_o, 1'b1);
    chk("s2_c5_pc", pc_o, 32'h0000_0000);

    // Five-cycle stall while memory streams: buffer fills, requests stop
    nxt(); rst_i = 1'b1; #2;
    nxt(); rst_i = 1'b0; #2;
    nxt(); #2;
    nxt(); #2;
    chk("s3_c2_pc", pc_o, 32'h0000_0000);
    nxt(); stall_i = 1'b1; #2;
    chk("s3_c3_pc", pc_o, 32'h0000_0004);
    nxt(); #2;
    chk1("s3_c4_req", imem_req_o, 1'b1);
    chk("s3_c4_addr", imem_addr_o, 32'h0000_0010);
    nxt(); #2;
    chk1("s3_c5_req", imem_req_o, 1'b0);
    nxt(); #2;
    nxt(); #2;
    chk1("s3_c7_req", imem_req_o, 1'b0);
    chk1("s3_c7_valid", instr_valid_o, 1'b1);
    chk("s3_c7_pc", pc_o, 32'h0000_0004);
    chk("s3_c7_instr", instruction_o, 32'h1000_0004);
    nxt(); stall_i = 1'b0; #2;
    chk("s3_c8_pc", pc_o, 32'h0000_0004);
    nxt(); #2;
    chk("s3_c9_pc", pc_o, 32'h0000_0008);
    chk1("s3_c9_req", imem_req_o, 1'b1);
    chk("s3_c9_addr", imem_addr_o, 32'h0000_0014);
    nxt(); #2;
    chk("s3_c10_pc", pc_o, 32'h0000_000C);
    nxt(); #2;
    chk("s3_c11_pc", pc_o, 32'h0000_0010);
    nxt(); #2;
    chk("s3_c12_pc", pc_o, 32'h0000_0014);
    chk("s3_c12_instr", instruction_o, 32'h1000_0014);

    // Latency 3, redirect to 0x103 with two requests in flight
    nxt(); rst_i = 1'b1; mem_lat = 3; #2;
    nxt(); rst_i = 1'b0; #2;
    chk("s4_c0_addr", imem_addr_o, 32'h0000_0000);
    nxt(); #2;
    chk("s4_c1_addr", imem_addr_o, 32'h0000_0004);
    nxt(); redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103; #2;
    chk1("s4_c2_req", imem_req_o, 1'b0);
    nxt(); redirect_i = 1'b0; #2;
    chk1("s4_c3_req", imem_req_o, 1'b1);
    chk("s4_c3_addr", imem_addr_o, 32'h0000_0100);
    chk1("s4_c3_valid", instr_valid_o, 1'b0);
    nxt(); #2;
    chk1("s4_c4_valid", instr_valid_o, 1'b0);
    chk("s4_c4_addr", imem_addr_o, 32'h0000_0104);
    nxt(); #2;
    chk1("s4_c5_valid", instr_valid_o, 1'b0);
    nxt(); #2;
    chk1("s4_c6_valid", instr_valid_o, 1'b0);
    nxt(); #2;
    chk1("s4_c7_valid", instr_valid_o, 1'b1);
    chk("s4_c7_pc", pc_o, 32'h0000_0100);
    chk("s4_c7_instr", instruction_o, 32'h1000_0100);
    chk("s4_c7_pcsrc", pcsrc_o, 32'h0000_0104);

    // Redirect coinciding with rvalid and an asserted gnt
    nxt(); rst_i = 1'b1; mem_lat = 1; #2;
    nxt(); rst_i = 1'b0; #2;
    chk("s5_c0_addr", imem_addr_o, 32'h0000_0000);
    nxt(); redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200; #2;
    chk1("s5_c1_req", imem_req_o, 1'b0);
    chk1("s5_c1_valid", instr_valid_o, 1'b0);
    nxt(); redirect_i = 1'b0; #2;
    chk1("s5_c2_req", imem_req_o, 1'b1);
    chk("s5_c2_addr", imem_addr_o, 32'h0000_0200);
    chk1("s5_c2_valid", instr_valid_o, 1'b0);
    nxt(); #2;
    chk1("s5_c3_valid", instr_valid_o, 1'b0);
    nxt(); #2;
    chk1("s5_c4_valid", instr_valid_o, 1'b1);
    chk("s5_c4_pc", pc_o, 32'h0000_0200);
    chk("s5_c4_instr", instruction_o, 32'h1000_0200);
    nxt(); #2;
    chk("s5_c5_pc", pc_o, 32'h0000_0204);

    // Reset mid-stream with three filled entries held by stall
    nxt(); rst_i = 1'b1; #2;
    nxt(); rst_i = 1'b0; stall_i = 1'b1; #2;
    nxt(); #2;
    nxt(); #2;
    chk1("s6_c2_valid", instr_valid_o, 1'b1);
    chk("s6_c2_pc", pc_o, 32'h0000_0000);
    nxt(); #2;
    chk("s6_c3_pc", pc_o, 32'h0000_0000);
    nxt(); rst_i = 1'b1; #2;
    chk1("s6_c4_req", imem_req_o, 1'b0);
    chk1("s6_c4_valid", instr_valid_o, 1'b0);
    nxt(); rst_i = 1'b0; stall_i = 1'b0; #2;
    chk1("s6_c5_valid", instr_valid_o, 1'b0);
    chk("s6_c5_instr", instruction_o, 32'h0000_0013);
    chk("s6_c5_pc", pc_o, 32'h0000_0000);
    chk1("s6_c5_req", imem_req_o, 1'b1);
    chk("s6_c5_addr", imem_addr_o, 32'h0000_0000);
    nxt(); #2;
    chk1("s6_c6_valid", instr_valid_o, 1'b0);
    nxt(); #2;
    chk1("s6_c7_valid", instr_valid_o, 1'b1);
    chk("s6_c7_pc", pc_o, 32'h0000_0000);
    chk("s6_c7_instr", instruction_o, 32'h0050_0093);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
